// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives a 1-cycle-latency instruction ROM,
// and buffers returned words with their PCs in a small queue feeding decode.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int          IQ_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic [31:0]               imem_addr_out,
  input  logic [31:0]               imem_data_in,
  input  logic                      redirect_valid_in,
  input  logic [31:0]               redirect_pc_in,
  output logic                      inst_valid_out,
  input  logic                      inst_ready_in,
  output logic [31:0]               inst_out,
  output logic [31:0]               inst_pc_out,
  output logic [$clog2(IQ_DEPTH):0] iq_count_out
);
  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_fetch_pc;
  logic          r_inflight_valid;
  logic [31:0]   r_inflight_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_q_inst [IQ_DEPTH];
  logic [31:0]   r_q_pc   [IQ_DEPTH];

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_occ;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & inst_ready_in;
  // Occupancy the queue will reach once the in-flight word lands and the head pops.
  assign w_occ   = {1'b0, r_count} - {{CW{1'b0}}, w_pop} + {{CW{1'b0}}, r_inflight_valid};
  assign w_issue = !redirect_valid_in && (w_occ < (CW+1)'(IQ_DEPTH));
  assign w_push  = r_inflight_valid & !redirect_valid_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc       <= PC_RESET;
      r_inflight_valid <= 1'b0;
      r_inflight_pc    <= '0;
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
    end else if (redirect_valid_in) begin
      r_fetch_pc       <= {redirect_pc_in[31:2], 2'b00};
      r_inflight_valid <= 1'b0;
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
    end else begin
      r_inflight_valid <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + PC_STEP;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: entries are only observed while counted as occupied.
  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_q_inst[r_wr_ptr] <= imem_data_in;
      r_q_pc[r_wr_ptr]   <= r_inflight_pc;
    end
  end

  assign imem_addr_out  = r_fetch_pc;
  assign inst_valid_out = w_valid;
  assign inst_out       = w_valid ? r_q_inst[r_rd_ptr] : '0;
  assign inst_pc_out    = w_valid ? r_q_pc[r_rd_ptr]   : '0;
  assign iq_count_out   = r_count;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random ready/redirect/reset
// traffic, checked every cycle against a queue-based reference model.
module tb_fetch_unit;
  localparam logic [31:0] PC_RESET = 32'h0040_0000;
  localparam int          DEPTH    = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr_out;
  logic [31:0] imem_data_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        inst_valid_out;
  logic        inst_ready_in;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic [2:0]  iq_count_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_fetch_pc;
  logic        m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] snap;

  fetch_unit #(.PC_RESET(PC_RESET), .PC_STEP(32'd4), .IQ_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .imem_addr_out(imem_addr_out), .imem_data_in(imem_data_in),
    .redirect_valid_in(redirect_valid_in), .redirect_pc_in(redirect_pc_in),
    .inst_valid_out(inst_valid_out), .inst_ready_in(inst_ready_in),
    .inst_out(inst_out), .inst_pc_out(inst_pc_out), .iq_count_out(iq_count_out)
  );

  always #5 clock = ~clock;

  // ROM contents: word i lives at PC_RESET + 4i.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a - PC_RESET) >> 2;
  endfunction

  always @(posedge clock) imem_data_in <= rom_word(imem_addr_out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    e_inst = (m_q.size() != 0) ? m_q[0].inst : 32'h0;
    e_pc   = (m_q.size() != 0) ? m_q[0].pc   : 32'h0;
    chk("addr",  imem_addr_out, m_fetch_pc);
    chk("valid", 32'(inst_valid_out), 32'(m_q.size() != 0));
    chk("inst",  inst_out, e_inst);
    chk("pc",    inst_pc_out, e_pc);
    chk("count", 32'(iq_count_out), 32'(m_q.size()));
  endtask

  // One clock cycle: drive inputs, advance the model by the rules, then compare.
  task automatic cycle(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc);
    bit pop;
    int occ;
    reset             = rst;
    inst_ready_in     = rdy;
    redirect_valid_in = rv;
    redirect_pc_in    = rpc;
    pop = (m_q.size() != 0) && rdy;
    if (rst) begin
      m_fetch_pc = PC_RESET;
      m_infl     = 1'b0;
      m_q.delete();
    end else if (rv) begin
      m_fetch_pc = {rpc[31:2], 2'b00};
      m_infl     = 1'b0;
      m_q.delete();
    end else begin
      occ = m_q.size() - int'(pop) + int'(m_infl);
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back('{inst: rom_word(m_infl_pc), pc: m_infl_pc});
      if (occ < DEPTH) begin
        m_infl     = 1'b1;
        m_infl_pc  = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    check_model();
  endtask

  task automatic redirect_check(input logic [31:0] target, input logic [31:0] exp_pc);
    cycle(0, 1, 1, target);
    chk("redir_n1_valid", 32'(inst_valid_out), 32'd0);
    chk("redir_n1_addr", imem_addr_out, exp_pc);
    cycle(0, 1, 0, 0);
    chk("redir_n2_valid", 32'(inst_valid_out), 32'd0);
    cycle(0, 1, 0, 0);
    chk("redir_n3_valid", 32'(inst_valid_out), 32'd1);
    chk("redir_n3_pc", inst_pc_out, exp_pc);
  endtask

  initial begin
    reset = 1'b1; inst_ready_in = 1'b0; redirect_valid_in = 1'b0; redirect_pc_in = '0;
    m_fetch_pc = PC_RESET; m_infl = 1'b0; m_infl_pc = '0;

    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("rst_addr",  imem_addr_out, PC_RESET);
    chk("rst_valid", 32'(inst_valid_out), 32'd0);
    chk("rst_inst",  inst_out, 32'd0);
    chk("rst_pc",    inst_pc_out, 32'd0);
    chk("rst_count", 32'(iq_count_out), 32'd0);

    // Latency after reset release, then gap-free streaming.
    cycle(0, 1, 0, 0);
    chk("lat1_valid", 32'(inst_valid_out), 32'd0);
    cycle(0, 1, 0, 0);
    chk("lat2_valid", 32'(inst_valid_out), 32'd1);
    chk("first_inst", inst_out, 32'd0);
    chk("first_pc",   inst_pc_out, PC_RESET);
    cycle(0, 1, 0, 0);
    chk("second_pc",  inst_pc_out, PC_RESET + 32'd4);
    repeat (8) cycle(0, 1, 0, 0);

    // Back-pressure: queue saturates and fetch address freezes.
    repeat (6) cycle(0, 0, 0, 0);
    snap = m_fetch_pc;
    repeat (4) cycle(0, 0, 0, 0);
    chk("sat_count",  32'(iq_count_out), 32'd4);
    chk("sat_frozen", imem_addr_out, snap);
    repeat (8) cycle(0, 1, 0, 0);

    // Three queued entries plus one in flight, then redirect.
    for (int k = 0; k < 20 && !(m_q.size() == 3 && m_infl); k++) cycle(0, 0, 0, 0);
    chk("pre_redir_count", 32'(iq_count_out), 32'd3);
    redirect_check(32'h0040_0100, 32'h0040_0100);
    repeat (3) cycle(0, 1, 0, 0);

    redirect_check(32'h0040_0102, 32'h0040_0100);
    repeat (2) cycle(0, 0, 0, 0);

    // Back-to-back redirects: only the second path survives.
    cycle(0, 1, 1, 32'h0040_0200);
    redirect_check(32'h0040_0300, 32'h0040_0300);
    repeat (3) cycle(0, 1, 0, 0);

    // PC wrap is silent.
    redirect_check(32'hFFFF_FFF8, 32'hFFFF_FFF8);
    repeat (6) cycle(0, 1, 0, 0);

    // Random traffic.
    repeat (500) begin
      int  r;
      bit  rst;
      bit  rv;
      bit  rdy;
      logic [31:0] rpc;
      r   = int'($urandom_range(0, 99));
      rst = (r < 1);
      rv  = (r >= 1) && (r < 7);
      rdy = ($urandom_range(0, 99) < 65);
      rpc = PC_RESET + (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(0, 3));
      cycle(rst, rdy, rv, rpc);
    end

    // Reset with a full queue.
    for (int k = 0; k < 20 && m_q.size() != DEPTH; k++) cycle(0, 0, 0, 0);
    chk("full_count", 32'(iq_count_out), 32'd4);
    cycle(1, 1, 0, 0);
    chk("midrst_count", 32'(iq_count_out), 32'd0);
    chk("midrst_valid", 32'(inst_valid_out), 32'd0);
    chk("midrst_addr",  imem_addr_out, PC_RESET);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    chk("midrst_head_pc", inst_pc_out, PC_RESET);
    repeat (4) cycle(0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the pipelined MIPS core. It owns the program counter and issues one word address per cycle to the synchronous instruction ROM (1-cycle read latency). Returned words are buffered with their PCs in a small instruction queue, which feeds decode over a valid/ready handshake. Branch, jump and jr resolution arrives as a single redirect request; on a redirect the unit discards all wrong-path work and restarts fetch at the target.

## Interface
- PC_RESET, 32'h0040_0000, first fetch address after reset
- PC_STEP, 4, PC increment per sequential fetch
- IQ_DEPTH, 4, instruction queue entries; power of two, ≥2
- clock  input  1  clock; all state updates on posedge
- reset  input  1  reset, synchronous, active-high
- imem_addr_out  output  32  address to inst_rom addr_in; always equals fetch_pc
- imem_data_in  input  32  inst_rom data_out; holds the word for the address sampled on the previous edge
- redirect_valid_in  input  1  redirect fetch this cycle
- redirect_pc_in  input  32  redirect target; bits [1:0] ignored, treated as 00
- inst_valid_out  output  1  queue head valid
- inst_ready_in  input  1  decode accepts head
- inst_out  output  32  head instruction; 0 when inst_valid_out=0
- inst_pc_out  output  32  PC of head instruction; 0 when inst_valid_out=0
- iq_count_out  output  $clog2(IQ_DEPTH)+1  current queue occupancy

## Operation
- State: fetch_pc (32), inflight_valid, inflight_pc (32), queue of IQ_DEPTH {inst, pc} entries with rd/wr pointers and count.
- pop = inst_valid_out & inst_ready_in.
- issue = !redirect_valid_in & ((count − pop + inflight_valid) < IQ_DEPTH). On issue: inflight_valid←1, inflight_pc←fetch_pc, fetch_pc←fetch_pc+PC_STEP (mod 2^32, wraps silently). Otherwise inflight_valid←0.
- push = inflight_valid & !redirect_valid_in: writes {imem_data_in, inflight_pc} at the tail. The issue rule guarantees push never overflows the queue.
- Simultaneous push and pop: count unchanged, and both pointers advance. Push into an empty queue becomes visible at the head on the next cycle, with no bypass.
- Redirect (has priority over everything except reset):
  - fetch_pc←{redirect_pc_in[31:2],2'b00}.
  - inflight_valid←0.
  - Queue cleared: count←0, pointers←0.
  - No issue and no push. A handshake completing in the same cycle counts as consumed, because decode owns that decision.
- Reset: fetch_pc←PC_RESET, inflight_valid←0, and the queue is emptied. Asserting reset mid-operation discards all queued and in-flight words, identical to a redirect to PC_RESET.
- No exception on fetch_pc wrap or on a misaligned target.

## Timing
- Reset values:
  - imem_addr_out=PC_RESET.
  - inst_valid_out=0, inst_out=0, inst_pc_out=0, iq_count_out=0.
- Fetch-to-decode latency is 2 cycles:
  - Address issued in cycle N.
  - Data pushed at the end of cycle N+1.
  - inst_valid_out=1 in cycle N+2.
- Redirect in cycle N:
  - imem_addr_out=target in N+1.
  - Target instruction valid at the head in N+3.
  - inst_valid_out=0 in N+1 and N+2.
- Throughput: with inst_ready_in held high, 1 instruction/cycle sustained for any IQ_DEPTH ≥ 2.
- Back-pressure:
  - With inst_ready_in held low, the queue fills to exactly IQ_DEPTH.
  - Issue stops once count + inflight_valid reaches IQ_DEPTH. After that, fetch_pc and imem_addr_out hold.
  - No instruction is lost or duplicated.
- inst_out, inst_pc_out and inst_valid_out come from registers and queue storage only, with no combinational path from inputs. The issue decision depends combinationally on inst_ready_in and redirect_valid_in.

## Test plan
- Reset, then ready=1 with a ROM of word i = i at PC_RESET+4i:
  - inst_valid_out first rises 2 cycles after reset deasserts.
  - The unit then delivers (inst, pc) = (0, 0x00400000), (1, 0x00400004), … on consecutive cycles with no bubbles.
- ready=0 for 10 cycles, with IQ_DEPTH=4:
  - iq_count_out saturates at 4 and imem_addr_out freezes.
  - After ready returns to 1, the sequence continues gap-free with no repeats.
- Redirect to 0x00400100 while the queue holds 3 entries and one fetch is in flight:
  - No old-path instruction appears after the redirect cycle.
  - Valid is low for 2 cycles, then the head is pc=0x00400100.
- Redirect to 0x00400102: the target is treated as 0x00400100.
- Redirect on consecutive cycles (to A, then B): only B-path instructions appear, starting 3 cycles after the second redirect.
- Reset asserted mid-stream with a full queue: the next cycle has iq_count_out=0 and inst_valid_out=0, and fetching restarts at PC_RESET.
